// File: rtl/rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decode_arbiter
//
// Round-robin arbiter for sixteen requesters that share one 4:16 decoded
// select bus. At most one requester owns the bus at a time. The owner's 4-bit
// index is kept in a register, and the one-hot grant is the decode of that
// registered index. The decoder is enabled by the registered valid flag.
// Because of this, grant has no combinational path from req.
//
// An owner keeps the bus until one of these happens: enable drops, the owner
// releases, the owner withdraws its request, or the owner has held the bus
// for MAX_HOLD cycles. Every grant is followed by one idle (bubble) cycle.
// The next search starts just after the previous owner, so that owner has the
// lowest priority in the next round.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   enable        global enable; low blocks new grants and revokes the owner
//   req[15:0]     request vector, bit i belongs to requester i
//   release_grant current owner is finished (only looked at while owning)
//   grant[15:0]   one-hot grant, 1<<grant_id while grant_valid, else 0
//   grant_id[3:0] index of the current owner; holds its last value when idle
//   grant_valid   a grant is active
//   hold_cnt[7:0] cycles the current grant has been held, starting at 0
// ---------------------------------------------------------------------------
module rr_decode_arbiter #(
    parameter int N        = 16,
    parameter int IDW      = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [N-1:0]   req,
    input  logic           release_grant,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic [7:0]     hold_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Value of hold_cnt during the last cycle an owner may keep the bus.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t         state_q,       state_d;
    logic [IDW-1:0] ptr_q,         ptr_d;
    logic [IDW-1:0] grant_id_q,    grant_id_d;
    logic           grant_valid_q, grant_valid_d;
    logic [7:0]     hold_cnt_q,    hold_cnt_d;

    logic           found;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] cand;
    logic           owner_exit;

    // 4:16 decoder with an enable input.
    function automatic logic [N-1:0] decode_4to16(input logic [IDW-1:0] idx,
                                                  input logic           en);
        logic [N-1:0] onehot;
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
        return onehot;
    endfunction

    // Round-robin search. Candidates are ptr+1, ptr+2, ... and wrap modulo 16
    // because of the 4-bit addition. The last candidate (offset 16 truncates
    // to 0) is ptr itself. So the previous owner is considered only when no
    // other requester is active.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        cand  = ptr_q;
        for (int off = 1; off <= N; off++) begin
            cand = ptr_q + IDW'(off);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Exit conditions for an owner. The action taken is the same for every
    // condition, so their order only documents why the owner lost the bus.
    assign owner_exit = !enable
                     || release_grant
                     || !req[grant_id_q]
                     || (hold_cnt_q == HOLD_LAST);

    // Next-state logic. On an exit the pointer is set to the owner's index.
    // This gives that owner the lowest priority in the next search, and the
    // pass through IDLE produces the one-cycle bubble between grants.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        hold_cnt_d    = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                grant_valid_d = 1'b0;
                hold_cnt_d    = 8'd0;
                if (enable && found) begin
                    state_d       = OWN;
                    grant_id_d    = sel;
                    grant_valid_d = 1'b1;
                end
            end
            OWN: begin
                if (owner_exit) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_id_q;
                    hold_cnt_d    = 8'd0;
                end else begin
                    hold_cnt_d    = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
                hold_cnt_d    = 8'd0;
            end
        endcase
    end

    // State registers. After reset the pointer is 15, so the first search
    // starts at requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '1;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    // Grant is decoded only from registered state. An asynchronous reset
    // clears grant_valid_q, so the grant drops without waiting for a clock.
    // Enable gates the bus through grant_valid: when enable is low, the owner
    // is revoked at the next edge.
    assign grant       = decode_4to16(grant_id_q, grant_valid_q);
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign hold_cnt    = hold_cnt_q;

endmodule
